// File: rtl/fnd_scan_controller_if.sv
// Load/convert request and scanned digit bundle
// for the FND scan controller.
interface fnd_scan_controller_if;
  logic        i_Load;
  logic [13:0] i_Binary;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Overflow;
  logic        o_EN;
  logic [1:0]  o_DigitSelect;
  logic [3:0]  o_Value;

  modport master (
    output i_Load,
    output i_Binary,
    input  o_Busy,
    input  o_Done,
    input  o_Overflow,
    input  o_EN,
    input  o_DigitSelect,
    input  o_Value
  );

  modport slave (
    input  i_Load,
    input  i_Binary,
    output o_Busy,
    output o_Done,
    output o_Overflow,
    output o_EN,
    output o_DigitSelect,
    output o_Value
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// Binary-to-BCD double-dabble converter with a
// time-multiplexed 4-digit scan and leading-zero blanking.
module fnd_scan_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  fnd_scan_controller_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    cnt;
  logic [13:0]   bin;
  logic [15:0]   bcd;
  logic [15:0]   disp;
  logic          ovf_pend;
  logic          ovf;
  logic [PW-1:0] presc;
  logic [1:0]    idx;

  logic          busy;
  logic          done;
  logic          load_go;
  logic [13:0]   clamp;
  logic [15:0]   bcd_adj;
  logic [29:0]   shf;
  logic          lead;

  assign clamp = (bus.i_Binary > 14'd9999) ?
                 14'd9999 : bus.i_Binary;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  assign shf = {bcd_adj, bin} << 1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    load_go  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_Load) begin
          load_go  = 1'b1;
          state_nx = CONVERT;
        end
      end
      CONVERT: begin
        busy = 1'b1;
        if (cnt == 4'd13) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt      <= '0;
      bin      <= '0;
      bcd      <= '0;
      disp     <= '0;
      ovf_pend <= 1'b0;
      ovf      <= 1'b0;
    end else if (load_go) begin
      cnt      <= '0;
      bin      <= clamp;
      bcd      <= '0;
      ovf_pend <= (bus.i_Binary > 14'd9999);
    end else if (state == CONVERT) begin
      cnt <= cnt + 4'd1;
      bin <= shf[13:0];
      bcd <= shf[29:14];
      // final shift lands straight in the display
      if (cnt == 4'd13) begin
        disp <= shf[29:14];
        ovf  <= ovf_pend;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    lead = 1'b1;
    unique case (idx)
      2'd1:    lead = |disp[15:4];
      2'd2:    lead = |disp[15:8];
      2'd3:    lead = |disp[15:12];
      default: lead = 1'b1;
    endcase
  end

  assign bus.o_Busy        = busy;
  assign bus.o_Done        = done;
  assign bus.o_Overflow    = ovf;
  assign bus.o_DigitSelect = idx;
  assign bus.o_Value       = disp[{idx, 2'b00} +: 4];
  assign bus.o_EN          = BLANK_LZ ? lead : 1'b1;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench: two instances (blanking on/off)
// compared against an arithmetic model of the display.
module tb_fnd_scan_controller;

  localparam int RD = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   k;
  int   disp_model;
  int   ovf_model;

  fnd_scan_controller_if bus1 ();
  fnd_scan_controller_if bus0 ();

  fnd_scan_controller #(
    .REFRESH_DIV (RD),
    .BLANK_LZ    (1'b1)
  ) dut1 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus1)
  );

  fnd_scan_controller #(
    .REFRESH_DIV (RD),
    .BLANK_LZ    (1'b0)
  ) dut0 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clock edges seen since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic drive(bit ld, int v);
    bus1.i_Load   = ld;
    bus1.i_Binary = 14'(v);
    bus0.i_Load   = ld;
    bus0.i_Binary = 14'(v);
  endtask

  function automatic int pow10(int i);
    int p;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    return p;
  endfunction

  task automatic check_scan();
    int ix;
    int dg;
    int en;
    ix = (k / RD) % 4;
    dg = (disp_model / pow10(ix)) % 10;
    en = (ix == 0 || disp_model >= pow10(ix)) ? 1 : 0;
    chk("sel1", 32'(bus1.o_DigitSelect), 32'(ix));
    chk("val1", 32'(bus1.o_Value), 32'(dg));
    chk("en1", 32'(bus1.o_EN), 32'(en));
    chk("ovf1", 32'(bus1.o_Overflow), 32'(ovf_model));
    chk("sel0", 32'(bus0.o_DigitSelect), 32'(ix));
    chk("val0", 32'(bus0.o_Value), 32'(dg));
    chk("en0", 32'(bus0.o_EN), 32'd1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, int'($urandom_range(0, 16383)));
      @(posedge clk);
      #1;
      chk("idle_busy", 32'(bus1.o_Busy), 32'd0);
      chk("idle_done", 32'(bus1.o_Done), 32'd0);
      check_scan();
    end
  endtask

  task automatic do_load(int v, int inject_at,
                         int abort_at);
    @(negedge clk);
    drive(1'b1, v);
    @(posedge clk);
    #1;
    chk("e0_busy", 32'(bus1.o_Busy), 32'd1);
    chk("e0_done", 32'(bus1.o_Done), 32'd0);
    check_scan();
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == inject_at) drive(1'b1, 8888);
      else drive(1'b0, int'($urandom_range(0, 16383)));
      @(posedge clk);
      #1;
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        disp_model = 0;
        ovf_model  = 0;
        chk("rst_busy", 32'(bus1.o_Busy), 32'd0);
        chk("rst_done", 32'(bus1.o_Done), 32'd0);
        chk("rst_ovf", 32'(bus1.o_Overflow), 32'd0);
        chk("rst_sel", 32'(bus1.o_DigitSelect), 32'd0);
        chk("rst_val", 32'(bus1.o_Value), 32'd0);
        chk("rst_en", 32'(bus1.o_EN), 32'd1);
        @(negedge clk);
        drive(1'b0, 0);
        rst_n = 1'b1;
        return;
      end
      if (n == 14) begin
        disp_model = (v > 9999) ? 9999 : v;
        ovf_model  = (v > 9999) ? 1 : 0;
        chk("e14_done", 32'(bus1.o_Done), 32'd1);
      end else begin
        chk("conv_done", 32'(bus1.o_Done), 32'd0);
      end
      chk("conv_busy", 32'(bus1.o_Busy), 32'd1);
      check_scan();
    end
    @(negedge clk);
    drive(1'b0, 0);
    @(posedge clk);
    #1;
    chk("e15_done", 32'(bus1.o_Done), 32'd0);
    chk("e15_busy", 32'(bus1.o_Busy), 32'd0);
    check_scan();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    disp_model = 0;
    ovf_model  = 0;
    drive(1'b0, 0);
    rst_n = 1'b0;
    #12;
    chk("por_busy", 32'(bus1.o_Busy), 32'd0);
    chk("por_done", 32'(bus1.o_Done), 32'd0);
    chk("por_ovf", 32'(bus1.o_Overflow), 32'd0);
    chk("por_sel", 32'(bus1.o_DigitSelect), 32'd0);
    chk("por_val", 32'(bus1.o_Value), 32'd0);
    chk("por_en", 32'(bus1.o_EN), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);

    do_load(1234, 0, 0);
    idle(16);
    do_load(57, 0, 0);
    idle(16);
    do_load(12000, 0, 0);
    idle(16);
    do_load(10, 0, 0);
    idle(16);
    do_load(2468, 5, 0);
    idle(20);
    do_load(4321, 0, 7);
    idle(24);

    for (int r = 0; r < 10; r++) begin
      do_load(int'($urandom_range(0, 16383)), 0, 0);
      idle(16);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
